// File: rtl/uart_rx_engine.sv
// uart_rx_engine: 16x-oversampled UART receiver. It synchronises the RX pin,
// validates the start bit, votes each bit 2-of-3 around mid-bit and presents
// each byte on a single-entry valid/ready output register.
module uart_rx_engine #(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 MAX10_CLK1_50,
    input  logic                 rst_n,
    input  logic                 baud_x16_tick,
    input  logic                 uart_rx,
    output logic                 rx_out_valid,
    input  logic                 rx_out_ready,
    output logic [DATA_BITS-1:0] rx_out_data,
    output logic                 rx_busy,
    output logic                 rx_frame_err,
    output logic                 rx_overrun
);

    localparam int unsigned CNT_W     = 4;
    localparam int unsigned IDX_W     = 4;
    localparam int unsigned START_MID = 7;
    localparam int unsigned SAMP_A    = 13;
    localparam int unsigned SAMP_B    = 14;
    localparam int unsigned SAMP_C    = 15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rxs;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_tick_cnt;
    logic [CNT_W-1:0]       w_tick_cnt_nxt;
    logic [IDX_W-1:0]       r_bit_idx;
    logic [IDX_W-1:0]       w_bit_idx_nxt;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   w_shift_nxt;
    logic [1:0]             r_samp;
    logic [1:0]             w_samp_nxt;

    logic                   w_maj;
    logic                   w_byte_done;
    logic                   w_stop_bad;
    logic                   w_accept;

    logic                   r_valid;
    logic                   w_valid_nxt;
    logic [DATA_BITS-1:0]   r_data;
    logic [DATA_BITS-1:0]   w_data_nxt;
    logic                   w_overrun_nxt;
    logic                   r_busy;
    logic                   r_frame_err;
    logic                   r_overrun;

    // Synchroniser on the raw pin; resets to the idle (high) level.
    always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], uart_rx};
        end
    end

    assign w_rxs    = r_sync[SYNC_STAGES-1];
    // 2-of-3 vote over the two stored samples and the one being taken now.
    assign w_maj    = (r_samp[0] & r_samp[1]) | (r_samp[0] & w_rxs) | (r_samp[1] & w_rxs);
    assign w_accept = r_valid & rx_out_ready;

    // State and bit-recovery registers.
    always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_tick_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_samp     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_tick_cnt <= w_tick_cnt_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_shift    <= w_shift_nxt;
            r_samp     <= w_samp_nxt;
        end
    end

    // Next-state, tick counting, sampling and LSB-first shifting.
    always_comb begin
        w_state_nxt    = r_state;
        w_tick_cnt_nxt = r_tick_cnt;
        w_bit_idx_nxt  = r_bit_idx;
        w_shift_nxt    = r_shift;
        w_samp_nxt     = r_samp;
        w_byte_done    = 1'b0;
        w_stop_bad     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (baud_x16_tick && !w_rxs) begin
                    w_state_nxt    = S_START;
                    w_tick_cnt_nxt = '0;
                end
            end
            S_START: begin
                if (baud_x16_tick) begin
                    if (r_tick_cnt == CNT_W'(START_MID)) begin
                        if (w_rxs) begin
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_state_nxt    = S_DATA;
                            w_tick_cnt_nxt = '0;
                            w_bit_idx_nxt  = '0;
                        end
                    end else begin
                        w_tick_cnt_nxt = CNT_W'(r_tick_cnt + 1'b1);
                    end
                end
            end
            S_DATA: begin
                if (baud_x16_tick) begin
                    w_tick_cnt_nxt = CNT_W'(r_tick_cnt + 1'b1);
                    if (r_tick_cnt == CNT_W'(SAMP_A)) w_samp_nxt[0] = w_rxs;
                    if (r_tick_cnt == CNT_W'(SAMP_B)) w_samp_nxt[1] = w_rxs;
                    if (r_tick_cnt == CNT_W'(SAMP_C)) begin
                        w_shift_nxt   = {w_maj, r_shift[DATA_BITS-1:1]};
                        w_bit_idx_nxt = IDX_W'(r_bit_idx + 1'b1);
                        if (r_bit_idx == IDX_W'(DATA_BITS - 1)) begin
                            w_state_nxt = S_STOP;
                        end
                    end
                end
            end
            S_STOP: begin
                if (baud_x16_tick) begin
                    w_tick_cnt_nxt = CNT_W'(r_tick_cnt + 1'b1);
                    if (r_tick_cnt == CNT_W'(SAMP_A)) w_samp_nxt[0] = w_rxs;
                    if (r_tick_cnt == CNT_W'(SAMP_B)) w_samp_nxt[1] = w_rxs;
                    if (r_tick_cnt == CNT_W'(SAMP_C)) begin
                        if (w_maj) begin
                            w_byte_done = 1'b1;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_stop_bad  = 1'b1;
                            w_state_nxt = S_BREAK;
                        end
                    end
                end
            end
            S_BREAK: begin
                // Hold off until the line returns high so a break never retriggers.
                if (baud_x16_tick && w_rxs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Single-entry output buffer: load, hold, drop-on-overrun, or drain.
    always_comb begin
        w_valid_nxt   = r_valid;
        w_data_nxt    = r_data;
        w_overrun_nxt = 1'b0;
        if (w_byte_done && (!r_valid || w_accept)) begin
            w_valid_nxt = 1'b1;
            w_data_nxt  = r_shift;
        end else if (w_byte_done) begin
            w_overrun_nxt = 1'b1;
        end else if (w_accept) begin
            w_valid_nxt = 1'b0;
        end
    end

    // Output registers and status pulses.
    always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_valid     <= w_valid_nxt;
            r_data      <= w_data_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_frame_err <= w_stop_bad;
            r_overrun   <= w_overrun_nxt;
        end
    end

    assign rx_out_valid = r_valid;
    assign rx_out_data  = r_data;
    assign rx_busy      = r_busy;
    assign rx_frame_err = r_frame_err;
    assign rx_overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_engine.sv
// tb_uart_rx_engine: drives 8N1 frames in x16-tick units and checks the
// receiver every cycle against a buffer/frame model built from the driver.
module tb_uart_rx_engine;

    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned GUARD    = 2000;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick  = 1'b0;
    logic       line  = 1'b1;
    logic       ready = 1'b1;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_busy;
    logic       rx_ferr;
    logic       rx_ovr;

    int checks = 0;
    int errors = 0;

    // Model of the expected DUT outputs.
    logic       m_valid = 1'b0;
    logic [7:0] m_data  = 8'h00;
    logic       m_ferr  = 1'b0;
    logic       m_ovr   = 1'b0;
    logic       m_busy  = 1'b0;
    int         m_acc   = 0;
    logic       m_take;
    logic       m_ok;

    // Driver-to-model handshake: the next tick edge is a stop decision.
    logic       done_flag = 1'b0;
    logic       done_err  = 1'b0;
    logic [7:0] done_byte = 8'h00;

    // Observed DUT events.
    int         n_vcyc = 0;
    int         n_acc  = 0;
    int         n_ferr = 0;
    int         n_ovr  = 0;
    logic [7:0] last_acc = 8'h00;

    bit chk_en       = 1'b0;
    bit tick_drop_en = 1'b0;
    int ready_mode   = 1;

    uart_rx_engine #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
        .MAX10_CLK1_50 (clk),
        .rst_n         (rst_n),
        .baud_x16_tick (tick),
        .uart_rx       (line),
        .rx_out_valid  (rx_valid),
        .rx_out_ready  (ready),
        .rx_out_data   (rx_data),
        .rx_busy       (rx_busy),
        .rx_frame_err  (rx_ferr),
        .rx_overrun    (rx_ovr)
    );

    always #5 clk = ~clk;

    // x16 tick every TICK_DIV cycles, optionally with random dropped ticks.
    initial begin
        forever begin
            repeat (TICK_DIV - 1) @(posedge clk);
            #1 tick = !(tick_drop_en && ($urandom_range(0, 7) == 0));
            @(posedge clk);
            #1 tick = 1'b0;
        end
    end

    // Consumer ready: forced low, forced high, or random.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       ready = 1'b0;
                1:       ready = 1'b1;
                default: ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Single-entry buffer behaviour evaluated at each clock edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0;
            m_data  = 8'h00;
            m_ferr  = 1'b0;
            m_ovr   = 1'b0;
        end else begin
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
            m_take = m_valid && ready;
            if (m_take) m_acc++;
            m_ok = done_flag && tick && !done_err;
            if (done_flag && tick && done_err) m_ferr = 1'b1;
            if (m_ok && (!m_valid || m_take)) begin
                m_valid = 1'b1;
                m_data  = done_byte;
            end else if (m_ok) begin
                m_ovr = 1'b1;
            end else if (m_take) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, plus event logging.
    always @(negedge clk) begin
        if (chk_en) begin
            check("valid", 32'(rx_valid), 32'(m_valid));
            check("data",  32'(rx_data),  32'(m_data));
            check("ferr",  32'(rx_ferr),  32'(m_ferr));
            check("ovr",   32'(rx_ovr),   32'(m_ovr));
            check("busy",  32'(rx_busy),  32'(m_busy));
            if (rst_n) begin
                if (rx_valid) n_vcyc++;
                if (rx_valid && ready) begin
                    n_acc++;
                    last_acc = rx_data;
                end
                if (rx_ferr) n_ferr++;
                if (rx_ovr) n_ovr++;
            end
        end
    end

    // Wait for n tick edges, then step just past the edge.
    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            int guard;
            guard = 0;
            do begin
                @(posedge clk);
                guard++;
            end while (tick !== 1'b1 && guard < GUARD);
            if (guard >= GUARD) begin
                errors++;
                $display("FAIL tick_timeout: no tick within %0d cycles", GUARD);
                $fatal(1, "tick generator stalled");
            end
        end
        if (n > 0) #1;
    endtask

    task automatic idle(input int n);
        line = 1'b1;
        wait_ticks(n);
    endtask

    // One 8N1 frame. gl_mask selects data bits that get a one-unit inverted
    // glitch at unit gl_unit; stop_low > 0 holds the stop bit low that many units.
    task automatic send_frame(input logic [7:0] b, input logic [7:0] gl_mask,
                              input int gl_unit, input int stop_low);
        line = 1'b0;
        wait_ticks(1);
        m_busy = 1'b1;
        wait_ticks(15);
        for (int i = 0; i < 8; i++) begin
            if (gl_mask[i]) begin
                line = b[i];
                wait_ticks(gl_unit);
                line = ~b[i];
                wait_ticks(1);
                line = b[i];
                wait_ticks(15 - gl_unit);
            end else begin
                line = b[i];
                wait_ticks(16);
            end
        end
        if (stop_low == 0) begin
            line = 1'b1;
            wait_ticks(8);
            done_byte = b;
            done_err  = 1'b0;
            done_flag = 1'b1;
            wait_ticks(1);
            done_flag = 1'b0;
            m_busy    = 1'b0;
            wait_ticks(7);
        end else begin
            line = 1'b0;
            wait_ticks(8);
            done_err  = 1'b1;
            done_flag = 1'b1;
            wait_ticks(1);
            done_flag = 1'b0;
            wait_ticks(stop_low - 9);
            line = 1'b1;
            wait_ticks(1);
            m_busy = 1'b0;
            wait_ticks(15);
        end
    endtask

    // Low pulse of g units (1..7) that the start-bit check must reject.
    task automatic false_start(input int g);
        line = 1'b0;
        wait_ticks(1);
        m_busy = 1'b1;
        wait_ticks(g - 1);
        line = 1'b1;
        wait_ticks(9 - g);
        m_busy = 1'b0;
        wait_ticks(8);
    endtask

    initial begin
        int v0;
        int a0;
        int f0;
        int o0;

        repeat (2) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_outputs", 32'({rx_valid, rx_data, rx_busy, rx_ferr, rx_ovr}), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(4);

        // Clean 0xA5 with ready high.
        v0 = n_vcyc; a0 = n_acc; f0 = n_ferr; o0 = n_ovr;
        send_frame(8'hA5, 8'h00, 0, 0);
        idle(2);
        check("a5_valid_cycles", 32'(n_vcyc - v0), 32'd1);
        check("a5_data", 32'(last_acc), 32'h0A5);
        check("a5_no_errors", 32'((n_ferr - f0) + (n_ovr - o0)), 32'd0);

        // Four-tick low glitch on an idle line.
        v0 = n_vcyc;
        false_start(4);
        idle(2);
        check("glitch_no_valid", 32'(n_vcyc - v0), 32'd0);

        // 0x3C with an inverted unit at the middle vote sample of every bit.
        a0 = n_acc;
        send_frame(8'h3C, 8'hFF, 7, 0);
        idle(2);
        check("glitch_acc", 32'(n_acc - a0), 32'd1);
        check("glitch_data", 32'(last_acc), 32'h03C);

        // 0x81 with stop held low for three bit times, then 0x42.
        a0 = n_acc; f0 = n_ferr;
        send_frame(8'h81, 8'h00, 0, 48);
        idle(2);
        check("break_ferr", 32'(n_ferr - f0), 32'd1);
        check("break_no_byte", 32'(n_acc - a0), 32'd0);
        send_frame(8'h42, 8'h00, 0, 0);
        idle(2);
        check("after_break_data", 32'(last_acc), 32'h042);
        check("after_break_acc", 32'(n_acc - a0), 32'd1);

        // Overrun: ready low, two back-to-back frames.
        ready_mode = 0;
        idle(2);
        a0 = n_acc; o0 = n_ovr;
        send_frame(8'h11, 8'h00, 0, 0);
        send_frame(8'h22, 8'h00, 0, 0);
        @(negedge clk);
        check("ovr_held_data", 32'(rx_data), 32'h011);
        check("ovr_held_valid", 32'(rx_valid), 32'd1);
        check("ovr_pulses", 32'(n_ovr - o0), 32'd1);
        ready_mode = 1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("ovr_drained", 32'(rx_valid), 32'd0);
        check("ovr_acc_data", 32'(last_acc), 32'h011);
        check("ovr_acc_count", 32'(n_acc - a0), 32'd1);
        idle(2);

        // Reset mid-DATA of 0x77, then 0x99.
        a0 = n_acc; f0 = n_ferr; o0 = n_ovr;
        line = 1'b0;
        wait_ticks(1);
        m_busy = 1'b1;
        wait_ticks(15);
        line = 1'b1;
        wait_ticks(40);
        rst_n  = 1'b0;
        m_busy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midreset_outputs", 32'({rx_valid, rx_data, rx_busy, rx_ferr, rx_ovr}), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(20);
        send_frame(8'h99, 8'h00, 0, 0);
        idle(2);
        check("midreset_acc", 32'(n_acc - a0), 32'd1);
        check("midreset_data", 32'(last_acc), 32'h099);
        check("midreset_no_err", 32'((n_ferr - f0) + (n_ovr - o0)), 32'd0);

        // Randomized traffic with dropped ticks and random back-pressure.
        tick_drop_en = 1'b1;
        ready_mode   = 2;
        for (int k = 0; k < 40; k++) begin
            int kind;
            logic [7:0] b;
            logic [7:0] msk;
            int gu;
            kind = int'($urandom_range(0, 9));
            b    = 8'($urandom);
            msk  = 8'($urandom);
            gu   = int'($urandom_range(0, 15));
            if (kind <= 5) begin
                send_frame(b, msk, gu, 0);
            end else if (kind == 6) begin
                false_start(int'($urandom_range(1, 7)));
            end else if (kind == 7) begin
                send_frame(b, msk, gu, int'($urandom_range(9, 40)));
            end else begin
                ready_mode = 0;
                send_frame(b, msk, gu, 0);
                send_frame(8'(~b), 8'h00, 0, 0);
                ready_mode = 2;
            end
            idle(int'($urandom_range(1, 12)));
        end

        tick_drop_en = 1'b0;
        ready_mode   = 1;
        idle(20);
        check("final_acc_count", 32'(n_acc), 32'(m_acc));
        check("final_drained", 32'(rx_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
